lab2_demux: RTL

Registered 2-bit 1-to-3 demultiplexer: the write-side counterpart of the Lab 2 2-bit 3-to-1 selector. A 2-bit word on the input switches is captured into one of three held channel registers U, V, W on each debounced Load press. The channel comes from a select code using the same encoding as the selector, or from an internal round-robin pointer in Auto mode. The three registers feed the existing selector directly, and per-channel valid flags plus a frame-complete pulse drive spare LEDs.

---
 rtl/lab2_demux.sv | 76 +++++++
 1 files changed

// File: rtl/lab2_demux.sv
// Registered 2-bit 1-to-3 demultiplexer: a debounced Load press captures D
// into channel U, V or W, chosen by S or by a round-robin pointer in Auto mode.
module lab2_demux #(
  parameter int WIDTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  input  logic             Load,
  input  logic             Auto,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [2:0]       Valid,
  output logic             Frame,
  output logic [1:0]       P
);

  // Write request protocol: Load is a level with no ready; each low-to-high
  // transition yields exactly one strobe cycle, and the write lands at the
  // edge that ends that cycle. ld_s/ld_d reset high so a held Load is ignored.
  logic       ld_s;
  logic       ld_d;
  logic       strobe;
  logic [1:0] sel;
  logic [2:0] wr_mask;
  logic [2:0] next_valid;

  assign strobe = ld_s & ~ld_d;

  // S[1] dominates, matching the selector's priority.
  always_comb begin
    sel = 2'd0;
    if (Auto)      sel = P;
    else if (S[1]) sel = 2'd2;
    else if (S[0]) sel = 2'd1;
    else           sel = 2'd0;
  end

  assign wr_mask    = 3'b001 << sel;
  assign next_valid = Valid | wr_mask;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ld_s  <= 1'b1;
      ld_d  <= 1'b1;
      U     <= '0;
      V     <= '0;
      W     <= '0;
      Valid <= 3'b000;
      Frame <= 1'b0;
      P     <= 2'd0;
    end else begin
      ld_s  <= Load;
      ld_d  <= ld_s;
      Frame <= 1'b0;
      if (strobe) begin
        case (sel)
          2'd0:    U <= D;
          2'd1:    V <= D;
          default: W <= D;
        endcase
        // A completing write clears the set and announces the frame.
        if (next_valid == 3'b111) begin
          Valid <= 3'b000;
          Frame <= 1'b1;
        end else begin
          Valid <= next_valid;
        end
        if (Auto) P <= (P == 2'd2) ? 2'd0 : P + 2'd1;
      end
    end
  end

endmodule
